seq_divider: RTL

Sequential signed 16-by-8 divider, the inverse companion of the 8x8 signed radix-4 Booth multiplier datapath: it takes a 16-bit signed product-width dividend and an 8-bit signed divisor and returns an 8-bit quotient and 8-bit remainder. It uses one non-restoring shift/subtract step per cycle behind valid/ready handshakes, so it can sit directly downstream of the multiplier or be fed by any streaming source.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_addsub.sv | 18 +
 rtl/seq_divider.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and saturation constants for the sequential divider.
package div_pkg;

    localparam int DW = 16;
    localparam int QW = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] Q_POS_SAT = 8'h7F;
    localparam logic [7:0] Q_NEG_SAT = 8'h80;
    localparam logic [7:0] Q_DBZ     = 8'hFF;

    // Saturated quotient for an overflowing divide, picked by the result sign.
    function automatic logic [7:0] sat_quot(input logic neg);
        return neg ? Q_NEG_SAT : Q_POS_SAT;
    endfunction

endpackage

// File: rtl/div_addsub.sv
// Add/subtract cell for the partial remainder; neg is the sign of the result.
module div_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         neg
);

    // Single adder shared by the iteration steps and the final restore.
    always_comb begin
        sum = sub ? (a - b) : (a + b);
        neg = sum[W-1];
    end

endmodule

// File: rtl/seq_divider.sv
// Signed DW/QW non-restoring divider, one quotient bit per cycle, valid/ready on both sides.
// The magnitude datapath assumes DW == 2*QW (product-width dividend).
module seq_divider #(
    parameter int DW = div_pkg::DW,
    parameter int QW = div_pkg::QW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [QW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [QW-1:0] remainder,
    output logic          div_by_zero,
    output logic          overflow
);
    import div_pkg::*;

    localparam int         PW   = QW + 1;
    localparam logic [3:0] LAST = 4'(QW - 1);

    state_t          state;
    logic [DW-1:0]   dd_r;
    logic [QW-1:0]   ds_r;
    logic            sign_q;
    logic            sign_r;
    logic [QW-1:0]   dabs;
    logic [PW-1:0]   p;
    logic [QW-1:0]   q_lo;      // low dividend bits shift out as quotient bits shift in
    logic [3:0]      cnt;
    logic            early;     // result already loaded in PREP; FIX only publishes it

    logic [DW-1:0]   dd_abs;
    logic [QW-1:0]   ds_abs;
    logic [PW-1:0]   as_a;
    logic [PW-1:0]   as_sum;
    logic            as_sub;
    logic            as_neg;
    logic [QW-1:0]   ru;
    logic            late_ovf;

    // Magnitudes of the latched operands; the most negative values map to 2^(W-1).
    always_comb begin
        dd_abs = dd_r[DW-1] ? (~dd_r + 1'b1) : dd_r;
        ds_abs = ds_r[QW-1] ? (~ds_r + 1'b1) : ds_r;
    end

    // Operand select: shift-and-step during ITER, plain restore-add during FIX.
    always_comb begin
        as_a   = {p[PW-2:0], q_lo[QW-1]};
        as_sub = ~p[PW-1];
        if (state == FIX) begin
            as_a   = p;
            as_sub = 1'b0;
        end
    end

    div_addsub #(.W(PW)) u_addsub (
        .a   (as_a),
        .b   ({1'b0, dabs}),
        .sub (as_sub),
        .sum (as_sum),
        .neg (as_neg)
    );

    // Final unsigned remainder and the late overflow test on the unsigned quotient.
    always_comb begin
        ru       = p[PW-1] ? as_sum[QW-1:0] : p[QW-1:0];
        late_ovf = sign_q ? (q_lo[QW-1] && (|q_lo[QW-2:0])) : q_lo[QW-1];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dd_r        <= '0;
            ds_r        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dabs        <= '0;
            p           <= '0;
            q_lo        <= '0;
            cnt         <= '0;
            early       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        dd_r        <= dividend;
                        ds_r        <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        in_ready    <= 1'b0;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    sign_q <= dd_r[DW-1] ^ ds_r[QW-1];
                    sign_r <= dd_r[DW-1];
                    dabs   <= ds_abs;
                    p      <= {1'b0, dd_abs[DW-1:QW]};
                    q_lo   <= dd_abs[QW-1:0];
                    cnt    <= '0;
                    early  <= 1'b0;
                    if (ds_r == '0) begin
                        quotient    <= Q_DBZ;
                        remainder   <= dd_r[QW-1:0];
                        div_by_zero <= 1'b1;
                        early       <= 1'b1;
                        state       <= FIX;
                    end else if (dd_abs[DW-1:QW] >= ds_abs) begin
                        // High half already >= divisor: quotient cannot fit in QW bits.
                        quotient  <= sat_quot(dd_r[DW-1] ^ ds_r[QW-1]);
                        remainder <= '0;
                        overflow  <= 1'b1;
                        early     <= 1'b1;
                        state     <= FIX;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    p    <= as_sum;
                    q_lo <= {q_lo[QW-2:0], ~as_neg};
                    cnt  <= cnt + 4'd1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (!early) begin
                        if (late_ovf) begin
                            quotient  <= sat_quot(sign_q);
                            remainder <= '0;
                            overflow  <= 1'b1;
                        end else begin
                            quotient  <= sign_q ? (~q_lo + 1'b1) : q_lo;
                            remainder <= sign_r ? (~ru + 1'b1) : ru;
                        end
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
